// File: rtl/isa_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : isa_bus_master
//  Purpose  : Turns single CPU-side requests into timed ISA I/O and memory
//             cycles. It runs setup, strobe and hold phases, honours target
//             wait states through bus_rdy with a bounded timeout, and splits
//             word reads into two byte cycles.
//  Options  : define ISA_SYNC_RDY_EN to pass bus_rdy/bus_dir through
//             two-flop synchronizers before use.
//  Revision : 1.0 - initial release
// ============================================================================
module isa_bus_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int RDY_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic        req_word,
    input  logic [19:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic [15:0] bus_d,
    output logic        word,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic        bus_aen,
    input  logic [7:0]  bus_din,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    localparam logic [7:0] C_SETUP_LAST  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] C_STROBE_LAST = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] C_HOLD_LAST   = 8'(HOLD_CYCLES - 1);
    localparam logic [8:0] C_TIMEOUT     = 9'(RDY_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        write_q, write_d;
    logic        io_q, io_d;
    logic        wreq_q, wreq_d;
    logic        phase_q, phase_d;
    logic        tmo_q, tmo_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  cap_q, cap_d;
    logic [19:0] bus_a_q, bus_a_d;
    logic [15:0] bus_d_q, bus_d_d;
    logic        word_q, word_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_tmo_q, rsp_tmo_d;

    logic        w_rdy;
    logic        w_dir;
    logic [7:0]  w_cap;
    logic        w_strobe;

`ifdef ISA_SYNC_RDY_EN
    logic [1:0] rdy_sync_q;
    logic [1:0] dir_sync_q;

    // Two-flop synchronizers for the asynchronous target handshake lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_sync_q <= 2'b11;
            dir_sync_q <= 2'b00;
        end else begin
            rdy_sync_q <= {rdy_sync_q[0], bus_rdy};
            dir_sync_q <= {dir_sync_q[0], bus_dir};
        end
    end

    assign w_rdy = rdy_sync_q[1];
    assign w_dir = dir_sync_q[1];
`else
    assign w_rdy = bus_rdy;
    assign w_dir = bus_dir;
`endif

    // A target that is not driving the bus reads back as a floating 0xFF
    assign w_cap = w_dir ? bus_din : 8'hFF;

    // Cycle sequencing: setup, strobe, wait states, hold and response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        write_d     = write_q;
        io_d        = io_q;
        wreq_d      = wreq_q;
        phase_d     = phase_q;
        tmo_d       = tmo_q;
        lo_d        = lo_q;
        cap_d       = cap_q;
        bus_a_d     = bus_a_q;
        bus_d_d     = bus_d_q;
        word_d      = word_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_tmo_d   = rsp_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    io_d    = req_io;
                    wreq_d  = req_word;
                    phase_d = 1'b0;
                    tmo_d   = 1'b0;
                    cnt_d   = 8'd0;
                    bus_a_d = req_io ? {4'h0, req_addr[15:0]} : req_addr;
                    bus_d_d = (req_word && req_write) ? req_wdata
                                                      : {8'h00, req_wdata[7:0]};
                    word_d  = req_word && req_write;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == C_SETUP_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == C_STROBE_LAST) begin
                    cnt_d  = 8'd0;
                    wcnt_d = 8'd0;
                    if (w_rdy) begin
                        cap_d   = w_cap;
                        state_d = S_HOLD;
                    end else if (RDY_TIMEOUT == 0) begin
                        // Wait states disabled: end the cycle as a timeout
                        cap_d   = 8'hFF;
                        tmo_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (w_rdy) begin
                    cap_d   = w_cap;
                    state_d = S_HOLD;
                end else if (({1'b0, wcnt_q} + 9'd1) >= C_TIMEOUT) begin
                    cap_d   = 8'hFF;
                    tmo_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (wcnt_q != 8'hFF) begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == C_HOLD_LAST) begin
                    cnt_d = 8'd0;
                    if (!write_q && wreq_q && !phase_q) begin
                        // Low byte done; run a second cycle for the high byte
                        phase_d = 1'b1;
                        lo_d    = cap_q;
                        bus_a_d = bus_a_q + 20'd1;
                        state_d = S_SETUP;
                    end else begin
                        rsp_tmo_d   = tmo_q;
                        rsp_rdata_d = write_q ? 16'h0000 :
                                      wreq_q  ? {cap_q, lo_q} : {8'h00, cap_q};
                        state_d     = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops straight back to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            wcnt_q      <= 8'd0;
            write_q     <= 1'b0;
            io_q        <= 1'b0;
            wreq_q      <= 1'b0;
            phase_q     <= 1'b0;
            tmo_q       <= 1'b0;
            lo_q        <= 8'd0;
            cap_q       <= 8'd0;
            bus_a_q     <= 20'd0;
            bus_d_q     <= 16'd0;
            word_q      <= 1'b0;
            rsp_rdata_q <= 16'd0;
            rsp_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            write_q     <= write_d;
            io_q        <= io_d;
            wreq_q      <= wreq_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            lo_q        <= lo_d;
            cap_q       <= cap_d;
            bus_a_q     <= bus_a_d;
            bus_d_q     <= bus_d_d;
            word_q      <= word_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    // Strobes decode straight from the state register so reset raises them at once
    assign w_strobe    = (state_q == S_STROBE) || (state_q == S_WAIT);
    assign bus_ior_l   = !(w_strobe &&  io_q && !write_q);
    assign bus_iow_l   = !(w_strobe &&  io_q &&  write_q);
    assign bus_memr_l  = !(w_strobe && !io_q && !write_q);
    assign bus_memw_l  = !(w_strobe && !io_q &&  write_q);

    assign req_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_tmo_q;
    assign bus_a       = bus_a_q;
    assign bus_d       = bus_d_q;
    assign word        = word_q;
    assign bus_aen     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_isa_bus_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_isa_bus_master
//  Purpose  : Directed self-checking bench for isa_bus_master with a simple
//             byte-addressed target model and a cycle-counting monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_isa_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_io, req_word;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic [19:0] bus_a;
    logic [15:0] bus_d;
    logic        word, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen;
    logic [7:0]  bus_din;
    logic        bus_dir, bus_rdy;
    logic [7:0]  din_lo, din_hi;

    int errors = 0;
    int checks = 0;

    // Results gathered by do_txn
    int          t_low, t_pulses, t_first, t_rsp, t_rspn;
    logic        t_other, t_w0, t_tmo, t_ready1, t_rdy_after;
    logic [19:0] t_a0, t_a1;
    logic [15:0] t_d0, t_rdata;

    always #5 clk = ~clk;

    // Target model: even addresses return din_lo, odd addresses din_hi
    assign bus_din = bus_a[0] ? din_hi : din_lo;

    isa_bus_master #(
        .SETUP_CYCLES (2),
        .STROBE_CYCLES(4),
        .HOLD_CYCLES  (1),
        .RDY_TIMEOUT  (255)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_io     (req_io),
        .req_word   (req_word),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_timeout(rsp_timeout),
        .bus_a      (bus_a),
        .bus_d      (bus_d),
        .word       (word),
        .bus_ior_l  (bus_ior_l),
        .bus_iow_l  (bus_iow_l),
        .bus_memr_l (bus_memr_l),
        .bus_memw_l (bus_memw_l),
        .bus_aen    (bus_aen),
        .bus_din    (bus_din),
        .bus_dir    (bus_dir),
        .bus_rdy    (bus_rdy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and watch the bus until one cycle past rsp_valid.
    // Cycle 1 is the first clock after acceptance. rdy_low_n is the number
    // of clocks bus_rdy is held low starting at the last nominal strobe clock.
    task automatic do_txn(input logic w, input logic io, input logic wd,
                          input logic [19:0] a, input logic [15:0] data,
                          input int rdy_low_n);
        logic [3:0] s, m;
        logic       cur_low, prev_low;
        int         j, n;
        t_low = 0; t_pulses = 0; t_first = 0; t_rsp = 0; t_rspn = 0;
        t_other = 1'b0; t_w0 = 1'b0; t_tmo = 1'b0; t_rdy_after = 1'b0;
        t_a0 = '0; t_a1 = '0; t_d0 = '0; t_rdata = '0;
        prev_low = 1'b0; j = 0; n = 0;
        m = {io & ~w, io & w, ~io & ~w, ~io & w};
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        req_valid = 1'b1; req_write = w; req_io = io; req_word = wd;
        req_addr = a; req_wdata = data;
        step();
        // Scramble the request inputs; they must have no effect now
        req_valid = 1'b1; req_write = ~w; req_io = ~io; req_word = ~wd;
        req_addr = 20'hFFFFF; req_wdata = 16'hDEAD;
        t_ready1 = req_ready;
        for (int k = 1; k <= 400; k++) begin
            s = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};
            cur_low = |(~s & m);
            if (|(~s & ~m)) t_other = 1'b1;
            if (cur_low) begin
                t_low++;
                j++;
                if (!prev_low) begin
                    t_pulses++;
                    if (t_pulses == 1) begin
                        t_first = k; t_a0 = bus_a; t_d0 = bus_d; t_w0 = word;
                    end else begin
                        t_a1 = bus_a;
                    end
                end
            end else begin
                j = 0;
            end
            prev_low = cur_low;
            if (t_rsp != 0 && k > t_rsp) begin
                t_rdy_after = req_ready;
                if (rsp_valid) t_rspn++;
                break;
            end
            if (rsp_valid) begin
                t_rspn++;
                t_rsp = k; t_rdata = rsp_rdata; t_tmo = rsp_timeout;
            end
            if (k == 1) req_valid = 1'b0;
            bus_rdy = !(cur_low && j >= 4 && j < 4 + rdy_low_n);
            step();
        end
        req_valid = 1'b0;
        bus_rdy = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0; req_word = 1'b0;
        req_addr = '0; req_wdata = '0;
        bus_dir = 1'b0; bus_rdy = 1'b1; din_lo = 8'h00; din_hi = 8'h00;
        repeat (3) step();
        checks++; if ({bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} !== 4'hF) begin
            errors++; $display("FAIL reset_strobes: got %b expected 1111",
                               {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l}); end
        checks++; if ({bus_a, bus_d, word, bus_aen} !== 38'd0) begin
            errors++; $display("FAIL reset_bus: got a=%h d=%h word=%b aen=%b expected zeros",
                               bus_a, bus_d, word, bus_aen); end
        checks++; if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if ({rsp_valid, rsp_rdata, rsp_timeout} !== 18'd0) begin
            errors++; $display("FAIL reset_rsp: got v=%b d=%h t=%b expected zeros",
                               rsp_valid, rsp_rdata, rsp_timeout); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_byte_io_write();
        do_txn(1'b1, 1'b1, 1'b0, 20'h003D8, 16'h552A, 0);
        checks++; if (t_ready1 !== 1'b0) begin
            errors++; $display("FAIL bw_ready_busy: got %b expected 0", t_ready1); end
        checks++; if (t_first !== 3 || t_a0 !== 20'h003D8) begin
            errors++; $display("FAIL bw_setup: got first_low=%0d a=%h expected 3 0003d8",
                               t_first, t_a0); end
        checks++; if (t_low !== 4 || t_pulses !== 1 || t_other !== 1'b0) begin
            errors++; $display("FAIL bw_strobe: got low=%0d pulses=%0d other=%b expected 4 1 0",
                               t_low, t_pulses, t_other); end
        checks++; if (t_d0 !== 16'h002A || t_w0 !== 1'b0) begin
            errors++; $display("FAIL bw_data: got d=%h word=%b expected 002a 0", t_d0, t_w0); end
        checks++; if (t_rsp !== 8 || t_rspn !== 1) begin
            errors++; $display("FAIL bw_rsp: got cycle=%0d count=%0d expected 8 1", t_rsp, t_rspn); end
    endtask

    task automatic test_word_io_write();
        do_txn(1'b1, 1'b1, 1'b1, 20'h003D4, 16'h0E07, 0);
        checks++; if (t_d0 !== 16'h0E07 || t_w0 !== 1'b1 || t_a0 !== 20'h003D4) begin
            errors++; $display("FAIL ww_data: got d=%h word=%b a=%h expected 0e07 1 003d4",
                               t_d0, t_w0, t_a0); end
        checks++; if (t_low !== 4 || t_pulses !== 1 || t_rspn !== 1 || t_other !== 1'b0) begin
            errors++; $display("FAIL ww_cycle: got low=%0d pulses=%0d rsp=%0d other=%b expected 4 1 1 0",
                               t_low, t_pulses, t_rspn, t_other); end
    endtask

    task automatic test_byte_io_read();
        bus_dir = 1'b1; din_lo = 8'hF9;
        do_txn(1'b0, 1'b1, 1'b0, 20'h003DA, 16'h0000, 0);
        checks++; if (t_rdata !== 16'h00F9 || t_tmo !== 1'b0 || t_rsp !== 8) begin
            errors++; $display("FAIL br_data: got d=%h tmo=%b cycle=%0d expected 00f9 0 8",
                               t_rdata, t_tmo, t_rsp); end
        checks++; if (t_low !== 4 || t_other !== 1'b0) begin
            errors++; $display("FAIL br_strobe: got low=%0d other=%b expected 4 0", t_low, t_other); end
        bus_dir = 1'b0;
        do_txn(1'b0, 1'b1, 1'b0, 20'h003DA, 16'h0000, 0);
        checks++; if (t_rdata !== 16'h00FF) begin
            errors++; $display("FAIL br_float: got %h expected 00ff", t_rdata); end
    endtask

    task automatic test_word_mem_read();
        bus_dir = 1'b1; din_lo = 8'h41; din_hi = 8'h07;
        do_txn(1'b0, 1'b0, 1'b1, 20'hB8000, 16'h0000, 0);
        checks++; if (t_pulses !== 2 || t_low !== 8 || t_other !== 1'b0) begin
            errors++; $display("FAIL wr_pulses: got pulses=%0d low=%0d other=%b expected 2 8 0",
                               t_pulses, t_low, t_other); end
        checks++; if (t_a0 !== 20'hB8000 || t_a1 !== 20'hB8001) begin
            errors++; $display("FAIL wr_addr: got %h %h expected b8000 b8001", t_a0, t_a1); end
        checks++; if (t_rdata !== 16'h0741 || t_rsp !== 15 || t_rspn !== 1) begin
            errors++; $display("FAIL wr_data: got d=%h cycle=%0d count=%0d expected 0741 15 1",
                               t_rdata, t_rsp, t_rspn); end
        do_txn(1'b0, 1'b0, 1'b1, 20'hFFFFF, 16'h0000, 0);
        checks++; if (t_a0 !== 20'hFFFFF || t_a1 !== 20'h00000 || t_rdata !== 16'h4107) begin
            errors++; $display("FAIL wr_wrap: got a0=%h a1=%h d=%h expected fffff 00000 4107",
                               t_a0, t_a1, t_rdata); end
    endtask

    task automatic test_wait_states();
        do_txn(1'b1, 1'b0, 1'b0, 20'hA0010, 16'h0033, 10);
        checks++; if (t_low !== 14 || t_pulses !== 1 || t_tmo !== 1'b0 || t_rspn !== 1) begin
            errors++; $display("FAIL ws_wait: got low=%0d pulses=%0d tmo=%b rsp=%0d expected 14 1 0 1",
                               t_low, t_pulses, t_tmo, t_rspn); end
        bus_dir = 1'b1; din_lo = 8'h5A;
        do_txn(1'b0, 1'b0, 1'b0, 20'hA0020, 16'h0000, 1000);
        checks++; if (t_low !== 259 || t_pulses !== 1) begin
            errors++; $display("FAIL ws_timeout_len: got low=%0d pulses=%0d expected 259 1",
                               t_low, t_pulses); end
        checks++; if (t_tmo !== 1'b1 || t_rdata !== 16'h00FF || t_rspn !== 1) begin
            errors++; $display("FAIL ws_timeout_rsp: got tmo=%b d=%h rsp=%0d expected 1 00ff 1",
                               t_tmo, t_rdata, t_rspn); end
        // Response fields hold after the pulse until the next completion
        checks++; if (rsp_timeout !== 1'b1 || rsp_rdata !== 16'h00FF) begin
            errors++; $display("FAIL ws_hold: got tmo=%b d=%h expected 1 00ff", rsp_timeout, rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        bus_dir = 1'b1; din_lo = 8'h12;
        do_txn(1'b0, 1'b1, 1'b0, 20'h00060, 16'h0000, 0);
        checks++; if (t_rdy_after !== 1'b1 || t_tmo !== 1'b0) begin
            errors++; $display("FAIL b2b_ready: got ready=%b tmo=%b expected 1 0", t_rdy_after, t_tmo); end
        do_txn(1'b1, 1'b0, 1'b0, 20'h12345, 16'h7788, 0);
        checks++; if (t_rsp !== 8 || t_d0 !== 16'h0088 || t_a0 !== 20'h12345) begin
            errors++; $display("FAIL b2b_second: got cycle=%0d d=%h a=%h expected 8 0088 12345",
                               t_rsp, t_d0, t_a0); end
    endtask

    task automatic test_reset_mid_strobe();
        int bad;
        bad = 0;
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_word = 1'b0;
        req_addr = 20'h003D9; req_wdata = 16'h0011;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        checks++; if (bus_iow_l !== 1'b0) begin
            errors++; $display("FAIL rm_pre: got iow_l=%b expected 0", bus_iow_l); end
        rst = 1'b1;
        #1;
        checks++; if (bus_iow_l !== 1'b1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rm_async: got iow_l=%b ready=%b rsp=%b expected 1 1 0",
                               bus_iow_l, req_ready, rsp_valid); end
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b0 || bus_iow_l !== 1'b1) bad++;
            step();
        end
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL rm_quiet: got %0d bad cycles expected 0", bad); end
        do_txn(1'b1, 1'b1, 1'b0, 20'h003D9, 16'h0021, 0);
        checks++; if (t_rsp !== 8 || t_low !== 4 || t_d0 !== 16'h0021) begin
            errors++; $display("FAIL rm_after: got cycle=%0d low=%0d d=%h expected 8 4 0021",
                               t_rsp, t_low, t_d0); end
    endtask

    initial begin
        test_reset();
        test_byte_io_write();
        test_word_io_write();
        test_byte_io_read();
        test_word_mem_read();
        test_wait_states();
        test_back_to_back();
        test_reset_mid_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
